pa2_seq_driver: RTL and testbench

- Initiator end of the pa2_fsm valid/num/seq → hit protocol.
- Accepts a burst request (length, target number, per-beat match mask) and drives a registered `valid`/`seq` burst toward pa2_fsm.
- Then watches the returned `hit` pulse train, counts it against the expected match count, and reports pass/fail.
- Used as the on-chip stimulus/checker for pa2_fsm, and as the producer side wherever the protocol is reused.

---
 rtl/pa2_seq_driver_if.sv | 57 +++++
 rtl/pa2_seq_driver.sv | 192 +++++++++++++++++++
 tb/tb_pa2_seq_driver.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pa2_seq_driver_if.sv
// ---------------------------------------------------------------------------
// pa2_seq_driver_if
//
// Bundles every non-clock signal of pa2_seq_driver: the burst request
// (start/len/num/mask), the link toward pa2_fsm (valid/num_o/seq out, hit
// back), and the check status (busy/done/pass/err/exp_cnt/hit_cnt).
//
// Modports:
//   master : the driver's view. Request and hit are inputs; link and status
//            are outputs.
//   slave  : the view of whoever issues requests, watches status and plays
//            the pa2_fsm role.
//
// Signals:
//   start    1        request strobe, acted on only while idle
//   len      4        requested beat count (0..15)
//   num      4        target number for the burst
//   mask     MAX_LEN  bit i=1: beat i carries num, bit i=0: beat i carries ~num
//   hit      1        hit pulse returned by pa2_fsm
//   valid    1        burst-active qualifier
//   num_o    4        captured target number
//   seq      4        current beat value
//   busy     1        driver is not idle
//   done     1        one-cycle end-of-check pulse
//   pass     1        result of the last check
//   err      1        protocol error seen during the last check
//   exp_cnt  4        expected hit count
//   hit_cnt  4        observed hit-high cycles, saturating at 15
// ---------------------------------------------------------------------------
interface pa2_seq_driver_if #(
  parameter int MAX_LEN = 10
);
  logic               start;
  logic [3:0]         len;
  logic [3:0]         num;
  logic [MAX_LEN-1:0] mask;
  logic               hit;
  logic               valid;
  logic [3:0]         num_o;
  logic [3:0]         seq;
  logic               busy;
  logic               done;
  logic               pass;
  logic               err;
  logic [3:0]         exp_cnt;
  logic [3:0]         hit_cnt;

  modport master (
    input  start, len, num, mask, hit,
    output valid, num_o, seq, busy, done, pass, err, exp_cnt, hit_cnt
  );

  modport slave (
    output start, len, num, mask, hit,
    input  valid, num_o, seq, busy, done, pass, err, exp_cnt, hit_cnt
  );
endinterface

// File: rtl/pa2_seq_driver.sv
// ---------------------------------------------------------------------------
// pa2_seq_driver
//
// Initiator end of the pa2_fsm valid/num/seq -> hit protocol. A request
// (length, target number, per-beat match mask) is turned into a registered
// burst of valid/seq beats. The driver then watches the returned hit pulse
// train for a fixed window, counts it against the number of matching beats
// and reports pass/fail.
//
// Parameters:
//   MAX_LEN : longest burst; longer requests are clamped to this
//   WINDOW  : cycles spent collecting hits after the last beat
//             (should be at least MAX_LEN+1 so a full hit run fits)
//
// Ports:
//   clock : system clock, every state update on its rising edge
//   reset : asynchronous, active-high; clears state and outputs at once
//   bus   : pa2_seq_driver_if master view (request, fsm link, status)
//
// Timing from the edge that accepts start (call it edge 0):
//   edges 0..L-1      register beats 0..L-1 (valid high for L cycles)
//   edge  L           valid and seq drop, collection begins
//   edges L+1..L+W    hit is sampled, one sample per window cycle
//   edge  L+W         done/pass registered (done visible for one cycle)
// so done is visible 1+L+WINDOW edges after the accepting edge.
// ---------------------------------------------------------------------------
module pa2_seq_driver #(
  parameter int MAX_LEN = 10,
  parameter int WINDOW  = 12
) (
  input  logic                      clock,
  input  logic                      reset,
  pa2_seq_driver_if.master          bus
);

  localparam int              WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [3:0]      MAX_LEN4 = 4'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    COLLECT,
    DONE
  } state_t;

  state_t             state;
  logic [MAX_LEN-1:0] burst_mask;  // request mask with out-of-range beats cleared
  logic [3:0]         burst_len;   // clamped beat count
  logic [3:0]         beat;        // index of the next beat to emit
  logic [WIN_W-1:0]   win;         // collection cycle counter
  logic               hit_seen;    // hit has been high in this window
  logic               hit_fell;    // hit has been high and then low again

  // -------------------------------------------------------------------------
  // Request decode: clamp the length and drop mask bits beyond it, so the
  // expected count only covers beats that are actually sent.
  // -------------------------------------------------------------------------
  logic [3:0]         eff_len;
  logic [MAX_LEN-1:0] eff_mask;
  logic [3:0]         eff_pop;

  assign eff_len = (bus.len > MAX_LEN4) ? MAX_LEN4 : bus.len;

  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_eff_mask
      assign eff_mask[gi] = bus.mask[gi] && (eff_len > 4'(gi));
    end
  endgenerate

  always_comb begin
    eff_pop = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      eff_pop = eff_pop + 4'(eff_mask[i]);
    end
  end

  // -------------------------------------------------------------------------
  // Collection bookkeeping for the current cycle. The final window cycle
  // must fold its own sample into the verdict, so pass is computed from
  // these updated values rather than from the registered ones.
  // -------------------------------------------------------------------------
  logic [3:0] hit_cnt_upd;
  logic       err_upd;

  always_comb begin
    hit_cnt_upd = bus.hit_cnt;
    if (bus.hit && (bus.hit_cnt != 4'hF)) begin
      hit_cnt_upd = bus.hit_cnt + 4'd1;
    end
    // A second rising run inside one window is a protocol error.
    err_upd = bus.err || (bus.hit && hit_fell);
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      burst_mask  <= '0;
      burst_len   <= '0;
      beat        <= '0;
      win         <= '0;
      hit_seen    <= 1'b0;
      hit_fell    <= 1'b0;
      bus.valid   <= 1'b0;
      bus.num_o   <= '0;
      bus.seq     <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.pass    <= 1'b0;
      bus.err     <= 1'b0;
      bus.exp_cnt <= '0;
      bus.hit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // hit is ignored here so late pulses cannot touch held results.
          if (bus.start) begin
            bus.num_o   <= bus.num;
            burst_mask  <= eff_mask;
            burst_len   <= eff_len;
            bus.exp_cnt <= eff_pop;
            bus.hit_cnt <= '0;
            bus.pass    <= 1'b0;
            bus.err     <= 1'b0;
            bus.busy    <= 1'b1;
            hit_seen    <= 1'b0;
            hit_fell    <= 1'b0;
            win         <= '0;
            if (eff_len != 4'd0) begin
              // Beat 0 goes out on this same edge so it appears the cycle
              // right after the request is accepted.
              state     <= SEND;
              bus.valid <= 1'b1;
              bus.seq   <= eff_mask[0] ? bus.num : ~bus.num;
              beat      <= 4'd1;
            end else begin
              state <= COLLECT;
            end
          end
        end

        SEND: begin
          // The responder must stay quiet while beats are still going out;
          // such hits flag an error and are not counted.
          if (bus.hit) begin
            bus.err <= 1'b1;
          end
          if (beat == burst_len) begin
            bus.valid <= 1'b0;
            bus.seq   <= '0;
            win       <= '0;
            state     <= COLLECT;
          end else begin
            bus.seq <= burst_mask[beat] ? bus.num_o : ~bus.num_o;
            beat    <= beat + 4'd1;
          end
        end

        COLLECT: begin
          bus.hit_cnt <= hit_cnt_upd;
          bus.err     <= err_upd;
          if (bus.hit) begin
            hit_seen <= 1'b1;
          end else if (hit_seen) begin
            hit_fell <= 1'b1;
          end
          if (win == WIN_LAST) begin
            bus.done <= 1'b1;
            bus.pass <= (hit_cnt_upd == bus.exp_cnt) && !err_upd;
            state    <= DONE;
          end else begin
            win <= win + 1'b1;
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pa2_seq_driver.sv
module tb_pa2_seq_driver;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  pa2_seq_driver_if #(.MAX_LEN(10)) bus ();

  pa2_seq_driver #(.MAX_LEN(10), .WINDOW(12)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Results recorded by do_burst for the test tasks to compare.
  logic [3:0] seq_log [16];
  int         nbeats;
  int         edges;
  int         done_edges;
  bit         got_done;
  logic [3:0] seq_after;

  // Issue one request and play the hit responder until done (bounded).
  // coll_pat bit k drives hit in collection cycle k; send_hit drives hit
  // throughout the beats; mid_start re-pulses start after that many beats.
  task automatic do_burst(input logic [3:0] l, input logic [3:0] n,
                          input logic [9:0] m, input logic [15:0] coll_pat,
                          input logic send_hit, input int mid_start);
    int coll_idx;
    int guard;
    @(negedge clock);
    bus.start = 1'b1; bus.len = l; bus.num = n; bus.mask = m; bus.hit = 1'b0;
    @(posedge clock);
    edges = 1;
    @(negedge clock);
    bus.start = 1'b0; bus.len = 4'd2; bus.num = 4'd0; bus.mask = '0;
    nbeats = 0; got_done = 0; coll_idx = 0; guard = 0; seq_after = 4'hF;
    done_edges = -1;
    while (!got_done && guard < 60) begin
      if (bus.done) begin
        got_done = 1; done_edges = edges; bus.hit = 1'b0;
      end else begin
        if (bus.valid) begin
          if (nbeats < 16) seq_log[nbeats] = bus.seq;
          nbeats++;
          bus.hit = send_hit;
        end else if (bus.busy) begin
          if (coll_idx == 0) seq_after = bus.seq;
          bus.hit = (coll_idx < 16) ? coll_pat[coll_idx] : 1'b0;
          coll_idx++;
        end else begin
          bus.hit = 1'b0;
        end
        bus.start = (nbeats == mid_start) ? 1'b1 : 1'b0;
        @(posedge clock);
        edges++;
        @(negedge clock);
        guard++;
      end
    end
    bus.start = 1'b0;
    bus.hit   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.num = '0; bus.mask = '0; bus.hit = 1'b0;
    #1;
    checks++;
    if ({bus.valid, bus.num_o, bus.seq, bus.busy, bus.done, bus.pass, bus.err,
         bus.exp_cnt, bus.hit_cnt} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {bus.valid, bus.num_o, bus.seq, bus.busy, bus.done, bus.pass,
                bus.err, bus.exp_cnt, bus.hit_cnt});
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_no_match;
    do_burst(4'd10, 4'd5, 10'h000, 16'h0000, 1'b0, -1);
    checks++;
    if (got_done !== 1'b1) begin errors++; $display("FAIL nm_done_seen: got %0d expected 1", got_done); end
    checks++;
    if (nbeats !== 10) begin errors++; $display("FAIL nm_beats: got %0d expected 10", nbeats); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (seq_log[i] !== 4'd10) begin errors++; $display("FAIL nm_seq[%0d]: got %0d expected 10", i, seq_log[i]); end
    end
    checks++;
    if (seq_after !== 4'd0) begin errors++; $display("FAIL nm_seq_after: got %0d expected 0", seq_after); end
    checks++;
    if (done_edges !== 23) begin errors++; $display("FAIL nm_latency: got %0d expected 23", done_edges); end
    checks++;
    if ({bus.exp_cnt, bus.hit_cnt, bus.pass, bus.err, bus.num_o} !== {4'd0, 4'd0, 1'b1, 1'b0, 4'd5}) begin
      errors++;
      $display("FAIL nm_result: got exp=%0d hit=%0d pass=%0d err=%0d num_o=%0d expected 0 0 1 0 5",
               bus.exp_cnt, bus.hit_cnt, bus.pass, bus.err, bus.num_o);
    end
    @(negedge clock);
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL nm_done_pulse: got done=%0d busy=%0d expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_all_match;
    do_burst(4'd10, 4'd5, 10'h3FF, 16'h03FF, 1'b0, -1);
    checks++;
    if (nbeats !== 10) begin errors++; $display("FAIL am_beats: got %0d expected 10", nbeats); end
    checks++;
    if (seq_log[0] !== 4'd5 || seq_log[9] !== 4'd5) begin
      errors++; $display("FAIL am_seq: got %0d,%0d expected 5,5", seq_log[0], seq_log[9]);
    end
    checks++;
    if ({bus.exp_cnt, bus.hit_cnt, bus.pass, bus.err} !== {4'd10, 4'd10, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL am_result: got exp=%0d hit=%0d pass=%0d err=%0d expected 10 10 1 0",
               bus.exp_cnt, bus.hit_cnt, bus.pass, bus.err);
    end
  endtask

  task automatic test_late_hit;
    // Hits arriving after the check must leave the held results alone.
    @(negedge clock);
    bus.hit = 1'b1;
    repeat (5) @(negedge clock);
    bus.hit = 1'b0;
    checks++;
    if ({bus.exp_cnt, bus.hit_cnt, bus.pass, bus.err, bus.busy} !== {4'd10, 4'd10, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL late_hit_hold: got exp=%0d hit=%0d pass=%0d err=%0d busy=%0d expected 10 10 1 0 0",
               bus.exp_cnt, bus.hit_cnt, bus.pass, bus.err, bus.busy);
    end
  endtask

  task automatic test_short_and_empty;
    do_burst(4'd1, 4'd7, 10'h001, 16'h0001, 1'b0, -1);
    checks++;
    if ({bus.exp_cnt, bus.hit_cnt, bus.pass} !== {4'd1, 4'd1, 1'b1} || nbeats !== 1 || seq_log[0] !== 4'd7) begin
      errors++;
      $display("FAIL len1: got exp=%0d hit=%0d pass=%0d beats=%0d seq=%0d expected 1 1 1 1 7",
               bus.exp_cnt, bus.hit_cnt, bus.pass, nbeats, seq_log[0]);
    end
    checks++;
    if (done_edges !== 14) begin errors++; $display("FAIL len1_latency: got %0d expected 14", done_edges); end
    do_burst(4'd0, 4'd7, 10'h3FF, 16'h0000, 1'b0, -1);
    checks++;
    if (nbeats !== 0) begin errors++; $display("FAIL len0_beats: got %0d expected 0", nbeats); end
    checks++;
    if (done_edges !== 13) begin errors++; $display("FAIL len0_latency: got %0d expected 13", done_edges); end
    checks++;
    if ({bus.exp_cnt, bus.hit_cnt, bus.pass, bus.err} !== {4'd0, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL len0_result: got exp=%0d hit=%0d pass=%0d err=%0d expected 0 0 1 0",
               bus.exp_cnt, bus.hit_cnt, bus.pass, bus.err);
    end
  endtask

  task automatic test_mismatch;
    // 0b0000010111 has four set bits; responder returns only three.
    do_burst(4'd10, 4'd3, 10'h017, 16'h0007, 1'b0, -1);
    checks++;
    if ({bus.exp_cnt, bus.hit_cnt, bus.pass, bus.err} !== {4'd4, 4'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL short_hits: got exp=%0d hit=%0d pass=%0d err=%0d expected 4 3 0 0",
               bus.exp_cnt, bus.hit_cnt, bus.pass, bus.err);
    end
    checks++;
    if (seq_log[3] !== 4'hC || seq_log[4] !== 4'd3) begin
      errors++; $display("FAIL mixed_seq: got %0d,%0d expected 12,3", seq_log[3], seq_log[4]);
    end
    // Broken run 1,0,1.
    do_burst(4'd10, 4'd3, 10'h017, 16'h0005, 1'b0, -1);
    checks++;
    if ({bus.hit_cnt, bus.pass, bus.err} !== {4'd2, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL split_run: got hit=%0d pass=%0d err=%0d expected 2 0 1", bus.hit_cnt, bus.pass, bus.err);
    end
    // Hit while beats are still being sent.
    do_burst(4'd10, 4'd3, 10'h3FF, 16'h03FF, 1'b1, -1);
    checks++;
    if ({bus.exp_cnt, bus.hit_cnt, bus.pass, bus.err} !== {4'd10, 4'd10, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL send_hit: got exp=%0d hit=%0d pass=%0d err=%0d expected 10 10 0 1",
               bus.exp_cnt, bus.hit_cnt, bus.pass, bus.err);
    end
  endtask

  task automatic test_clamp;
    do_burst(4'd15, 4'd9, 10'h3FF, 16'h03FF, 1'b0, 4);
    checks++;
    if (nbeats !== 10 || done_edges !== 23) begin
      errors++; $display("FAIL clamp_len: got beats=%0d edges=%0d expected 10 23", nbeats, done_edges);
    end
    checks++;
    if ({bus.exp_cnt, bus.pass, bus.num_o, seq_log[9]} !== {4'd10, 1'b1, 4'd9, 4'd9}) begin
      errors++;
      $display("FAIL clamp_result: got exp=%0d pass=%0d num_o=%0d seq9=%0d expected 10 1 9 9",
               bus.exp_cnt, bus.pass, bus.num_o, seq_log[9]);
    end
    // Mask bits at or above the length are not expected to hit.
    do_burst(4'd3, 4'd1, 10'h3FF, 16'h0007, 1'b0, -1);
    checks++;
    if ({bus.exp_cnt, bus.pass} !== {4'd3, 1'b1} || nbeats !== 3) begin
      errors++; $display("FAIL mask_trim: got exp=%0d pass=%0d beats=%0d expected 3 1 3", bus.exp_cnt, bus.pass, nbeats);
    end
  endtask

  task automatic test_reset_mid_send;
    @(negedge clock);
    bus.start = 1'b1; bus.len = 4'd10; bus.num = 4'd6; bus.mask = 10'h3FF;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({bus.valid, bus.seq} !== {1'b1, 4'd6}) begin
      errors++; $display("FAIL mid_send_active: got valid=%0d seq=%0d expected 1 6", bus.valid, bus.seq);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.valid, bus.busy, bus.seq, bus.num_o} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: got valid=%0d busy=%0d seq=%0d num_o=%0d expected 0 0 0 0",
               bus.valid, bus.busy, bus.seq, bus.num_o);
    end
    @(negedge clock);
    reset = 1'b0;
    do_burst(4'd4, 4'd2, 10'h00A, 16'h0003, 1'b0, -1);
    checks++;
    if ({bus.exp_cnt, bus.hit_cnt, bus.pass, bus.err} !== {4'd2, 4'd2, 1'b1, 1'b0} || done_edges !== 17) begin
      errors++;
      $display("FAIL after_reset: got exp=%0d hit=%0d pass=%0d err=%0d edges=%0d expected 2 2 1 0 17",
               bus.exp_cnt, bus.hit_cnt, bus.pass, bus.err, done_edges);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_no_match();
    test_all_match();
    test_late_hit();
    test_short_and_empty();
    test_mismatch();
    test_clamp();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
